message_scroller: RTL and testbench

MESSAGE_SCROLLER -- requirements
Module: message_scroller

---
 rtl/message_scroller.sv | 97 +++++++++
 tb/tb_message_scroller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_scroller.sv
// Scrolls a message from a combinational character source across a 4-digit window; SCROLL_GAP_EN adds a 4-blank gap between repetitions.
// Latency: digits, step and wrap update on the clock edge of each prescaler tick (PRESCALE enabled cycles apart).
// No backpressure: enable=0 freezes all state and the source must answer counter_caracter in the same cycle.
module message_scroller #(
    parameter int         PRESCALE = 50000000,
    parameter logic [3:0] BLANK    = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [3:0]  caracter,
    input  logic [3:0]  len_string,
    output logic [3:0]  counter_caracter,
    output logic [15:0] digits,
    output logic        step,
    output logic        wrap
);

    localparam logic [25:0] PRE_LAST = 26'(PRESCALE - 1);

    typedef enum logic {RUN, GAP} state_t;

    state_t      state_q, state_d;
    logic [25:0] presc_q, presc_d;
    logic [1:0]  gap_q, gap_d;
    logic [3:0]  cnt_d;
    logic [15:0] digits_d;
    logic        step_d, wrap_d;
    logic        tick;

    assign tick = enable && (presc_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            presc_q          <= '0;
            gap_q            <= '0;
            counter_caracter <= '0;
            digits           <= {4{BLANK}};
            step             <= 1'b0;
            wrap             <= 1'b0;
        end else begin
            state_q          <= state_d;
            presc_q          <= presc_d;
            gap_q            <= gap_d;
            counter_caracter <= cnt_d;
            digits           <= digits_d;
            step             <= step_d;
            wrap             <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        gap_d    = gap_q;
        cnt_d    = counter_caracter;
        digits_d = digits;
        step_d   = 1'b0;
        wrap_d   = 1'b0;

        if (enable) begin
            presc_d = tick ? 26'd0 : presc_q + 26'd1;
        end

        if (tick) begin
            case (state_q)
                RUN: begin
                    digits_d = {digits[11:0], caracter};
                    step_d   = 1'b1;
                    // >= rather than == keeps the index legal if len_string shrinks mid-message
                    if (counter_caracter >= len_string) begin
                        cnt_d  = 4'd0;
                        wrap_d = 1'b1;
`ifdef SCROLL_GAP_EN
                        state_d = GAP;
                        gap_d   = 2'd0;
`endif
                    end else begin
                        cnt_d = counter_caracter + 4'd1;
                    end
                end
                GAP: begin
                    digits_d = {digits[11:0], BLANK};
                    step_d   = 1'b1;
                    cnt_d    = 4'd0;
                    gap_d    = gap_q + 2'd1;
                    if (gap_q == 2'd3) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_message_scroller.sv
// Bench for message_scroller at PRESCALE=2: directed scenarios plus a randomized run against a queue-based reference model.
module tb_message_scroller;

    localparam int         PRESCALE = 2;
    localparam logic [3:0] BLANK    = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  caracter;
    logic [3:0]  len_string = 4'd5;
    logic [3:0]  counter_caracter;
    logic [15:0] digits;
    logic        step, wrap;

    logic [3:0]  msg [16];

    int n_cmp = 0;
    int n_fail = 0;

    // reference model: window as a queue of characters, gap as a countdown of pending blanks
    logic [3:0] m_win [$];
    int         m_idx, m_pre, m_gap;
    logic       m_step, m_wrap;

    assign caracter = msg[counter_caracter];

    always #5 clk = ~clk;

    message_scroller #(.PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .caracter(caracter),
        .len_string(len_string),
        .counter_caracter(counter_caracter),
        .digits(digits),
        .step(step),
        .wrap(wrap)
    );

    function automatic logic [15:0] m_digits();
        return {m_win[0], m_win[1], m_win[2], m_win[3]};
    endfunction

    task automatic model_reset();
        m_win = '{BLANK, BLANK, BLANK, BLANK};
        m_idx = 0; m_pre = 0; m_gap = 0; m_step = 0; m_wrap = 0;
    endtask

    task automatic load_default_msg();
        for (int i = 0; i < 16; i++) msg[i] = 4'h9;
        msg[0] = 4'h0; msg[1] = 4'h1; msg[2] = 4'h3;
        msg[3] = 4'h4; msg[4] = 4'hA; msg[5] = 4'h7;
    endtask

    // advances the model with the inputs present before the edge, then steps one clock
    task automatic cycle();
        m_step = 0;
        m_wrap = 0;
        if (!rst_n) begin
            model_reset();
        end else if (enable) begin
            if (m_pre == PRESCALE - 1) begin
                m_pre = 0;
                m_step = 1;
                void'(m_win.pop_front());
                if (m_gap > 0) begin
                    m_win.push_back(BLANK);
                    m_gap--;
                end else begin
                    m_win.push_back(msg[m_idx]);
                    if (m_idx >= int'(len_string)) begin
                        m_idx = 0;
                        m_wrap = 1;
`ifdef SCROLL_GAP_EN
                        m_gap = 4;
`endif
                    end else begin
                        m_idx++;
                    end
                end
            end else begin
                m_pre++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (digits !== 16'hFFFF || counter_caracter !== 4'd0 || step !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got digits=%h cnt=%0d step=%b wrap=%b want FFFF 0 0 0",
                     digits, counter_caracter, step, wrap);
        end
        repeat (3) cycle();
        n_cmp++;
        if (digits !== 16'hFFFF || counter_caracter !== 4'd0 || step !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: got digits=%h cnt=%0d step=%b wrap=%b want FFFF 0 0 0",
                     digits, counter_caracter, step, wrap);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        int steps = 0, wraps = 0;
        enable = 1'b1;
        repeat (8) begin
            cycle();
            steps += int'(step);
            wraps += int'(wrap);
        end
        n_cmp++;
        if (digits !== 16'h0134 || counter_caracter !== 4'd4) begin
            n_fail++;
            $display("FAIL fill_state: got digits=%h cnt=%0d want 0134 4", digits, counter_caracter);
        end
        n_cmp++;
        if (steps != 4 || wraps != 0) begin
            n_fail++;
            $display("FAIL fill_pulses: got steps=%0d wraps=%0d want 4 0", steps, wraps);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_gap [5];
        exp_gap = '{16'h4A7F, 16'hA7FF, 16'h7FFF, 16'hFFFF, 16'hFFF0};
        repeat (4) cycle();
        n_cmp++;
        if (digits !== 16'h34A7 || counter_caracter !== 4'd0 || step !== 1'b1 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_tick6: got digits=%h cnt=%0d step=%b wrap=%b want 34A7 0 1 1",
                     digits, counter_caracter, step, wrap);
        end
`ifdef SCROLL_GAP_EN
        for (int t = 0; t < 5; t++) begin
            repeat (2) cycle();
            n_cmp++;
            if (digits !== exp_gap[t] || counter_caracter !== (t == 4 ? 4'd1 : 4'd0) || step !== 1'b1 || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_tick%0d: got digits=%h cnt=%0d step=%b wrap=%b want %h",
                         t + 7, digits, counter_caracter, step, wrap, exp_gap[t]);
            end
        end
`else
        repeat (2) cycle();
        n_cmp++;
        if (digits !== 16'h4A70 || counter_caracter !== 4'd1 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_tick7: got digits=%h cnt=%0d wrap=%b want 4A70 1 0",
                     digits, counter_caracter, wrap);
        end
`endif
    endtask

    task automatic test_freeze();
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        repeat (6) cycle();
        enable = 1'b0;
        repeat (10) begin
            cycle();
            n_cmp++;
            if (digits !== 16'hF013 || counter_caracter !== 4'd3 || step !== 1'b0 || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze_hold: got digits=%h cnt=%0d step=%b wrap=%b want F013 3 0 0",
                         digits, counter_caracter, step, wrap);
            end
        end
        enable = 1'b1;
        cycle();
        n_cmp++;
        if (digits !== 16'hF013) begin
            n_fail++;
            $display("FAIL freeze_resume1: got %h want F013", digits);
        end
        cycle();
        n_cmp++;
        if (digits !== 16'h0134 || counter_caracter !== 4'd4 || step !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze_resume2: got digits=%h cnt=%0d step=%b want 0134 4 1",
                     digits, counter_caracter, step);
        end
    endtask

    task automatic test_len_zero();
        int wraps = 0, ticks = 0;
        enable = 1'b0;
        len_string = 4'd0;
        do_reset();
        enable = 1'b1;
        repeat (8) begin
            cycle();
            ticks += int'(step);
            wraps += int'(wrap);
            n_cmp++;
            if (digits !== m_digits() || counter_caracter !== 4'd0 || wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL len0_cycle: got digits=%h cnt=%0d wrap=%b want %h 0 %b",
                         digits, counter_caracter, wrap, m_digits(), m_wrap);
            end
        end
`ifndef SCROLL_GAP_EN
        n_cmp++;
        if (digits !== 16'h0000 || wraps != 4 || ticks != 4) begin
            n_fail++;
            $display("FAIL len0_fill: got digits=%h wraps=%0d steps=%0d want 0000 4 4", digits, wraps, ticks);
        end
`endif
    endtask

    task automatic test_len_drop();
        enable = 1'b0;
        len_string = 4'd5;
        do_reset();
        enable = 1'b1;
        repeat (8) cycle();
        len_string = 4'd2;
        repeat (2) cycle();
        n_cmp++;
        if (digits !== 16'h134A || counter_caracter !== 4'd0 || wrap !== 1'b1 || step !== 1'b1) begin
            n_fail++;
            $display("FAIL len_drop: got digits=%h cnt=%0d wrap=%b step=%b want 134A 0 1 1",
                     digits, counter_caracter, wrap, step);
        end
        len_string = 4'd5;
    endtask

    task automatic test_random();
        enable = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) msg[i] = 4'($urandom_range(0, 15));
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 49) == 0) len_string = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) msg[$urandom_range(0, 15)] = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 399) != 0);
            cycle();
            n_cmp++;
            if (digits !== m_digits() || counter_caracter !== 4'(m_idx) || step !== m_step || wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL random_c%0d: got digits=%h cnt=%0d step=%b wrap=%b want %h %0d %b %b",
                         c, digits, counter_caracter, step, wrap, m_digits(), m_idx, m_step, m_wrap);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        load_default_msg();
        model_reset();
        test_reset();
        test_fill();
        test_wrap();
        test_freeze();
        test_len_zero();
        test_len_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
